uart_cmd_responder: RTL and testbench
=====================================

# uart_cmd_responder

Byte-level command responder on the user side of the UART: consumes received bytes (`rx_valid`/`rx_data`), decodes register read/write frames from a host, performs the access on a simple register bus, and returns one response byte through the transmitter handshake (`tx_valid`/`tx_data`/`tx_busy`). It is the device end of the host register-access protocol. It sits between the `uart` top and the chip register file, in the 50 MHz `clk` domain.

## Interface
- `TIMEOUT_CYCLES`, 50000: idle cycles allowed between bytes of one frame before the frame is aborted (1 ms at 50 MHz); must be ≥ 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `rx_valid`  in  1  one-cycle strobe, `rx_data` holds a received byte.
- `rx_data`  in  8  received byte.
- `tx_valid`  out  1  one-cycle strobe requesting transmission of `tx_data`.
- `tx_data`  out  8  response byte; held stable from `tx_valid` until the state returns to IDLE.
- `tx_busy`  in  1  transmitter busy. It goes high the cycle after an accepted `tx_valid` and falls when the stop bit completes.
- `reg_wr_en`  out  1  one-cycle register write strobe.
- `reg_rd_en`  out  1  one-cycle register read strobe.
- `reg_addr`  out  8  register address.
- `reg_wdata`  out  8  write data.
- `reg_rdata`  in  8  read data, valid the cycle after `reg_rd_en`.
- `busy`  out  1  high whenever the state is not IDLE.
- `frame_err`  out  1  one-cycle pulse on NAK, timeout or overrun.

## Operation
- Frame formats from the host:
  - Write: `0x57` ('W'), addr, data. Response is `0x06` (ACK).
  - Read: `0x52` ('R'), addr. Response is the read data byte.
  - Any other first byte: response is `0x15` (NAK). No register access.
- States:
  - IDLE: on a byte equal to W or R, latch the opcode and go to ADDR. On any other byte, load NAK and go to TX_REQ.
  - ADDR: on a byte, latch `reg_addr`. For W go to DATA. For R go to CSUM if enabled, else ACCESS.
  - DATA: on a byte, latch `reg_wdata`. Go to CSUM if enabled, else ACCESS.
  - CSUM (compiled in only): see Configuration.
  - ACCESS: pulse `reg_wr_en` (W) or `reg_rd_en` (R) for exactly one cycle. W loads ACK and goes to TX_REQ; R goes to RDWAIT.
  - RDWAIT: capture `reg_rdata` into `tx_data`, go to TX_REQ.
  - TX_REQ: wait until `tx_busy` = 0, then pulse `tx_valid` for one cycle and go to TX_WAIT.
  - TX_WAIT: skip one cycle (busy rising), then wait for `tx_busy` = 0, then go to IDLE.
- Inter-byte timeout:
  - The counter reloads to 0 on entry to ADDR/DATA/CSUM and on every `rx_valid`.
  - When it reaches `TIMEOUT_CYCLES`-1 while still waiting, the frame is aborted: go to IDLE, pulse `frame_err`, send no response.
  - The counter width is `$clog2(TIMEOUT_CYCLES)`.
- Overrun: an `rx_valid` in ACCESS, RDWAIT, TX_REQ or TX_WAIT is dropped and pulses `frame_err`. The state is unaffected.
- A NAK response also pulses `frame_err` in the cycle the NAK is loaded.
- `reg_addr`/`reg_wdata` hold their last latched values between frames.

## Timing
- Reset values: `tx_valid`, `reg_wr_en`, `reg_rd_en`, `frame_err` and `busy` = 0. `tx_data`, `reg_addr` and `reg_wdata` = 0x00. State = IDLE, timeout counter = 0.
- Reset asserted mid-frame or mid-response returns to IDLE on the next edge. `tx_valid` is never asserted in the reset cycle.
- Write latency: last frame byte's `rx_valid` at cycle N, `reg_wr_en` at N+1, `tx_valid` at N+2 if `tx_busy` = 0.
- Read latency: last byte at N, `reg_rd_en` at N+1, `rdata` captured at N+2, `tx_valid` at N+3 if not busy.
- If `tx_busy` is still high from a previous frame, `tx_valid` is deferred until the first cycle with `tx_busy` = 0.
- `rx_valid` in the same cycle a timeout fires: the byte wins, and the counter reloads.

## Configuration
- `UART_CMD_CHECKSUM_EN` defined:
  - Every frame carries one extra trailing byte, equal to the XOR of all preceding frame bytes.
  - The CSUM state compares it with the running XOR.
  - On a match, go to ACCESS.
  - On a mismatch, load NAK, pulse `frame_err`, perform no register access, and go to TX_REQ.
- Undefined: no CSUM state, no XOR register, and frames are exactly as listed above.

## Test plan
- Write frame 0x57,0x10,0xA5 → one `reg_wr_en` pulse with addr 0x10, wdata 0xA5; `tx_valid` once with `tx_data` 0x06.
- Read frame 0x52,0x22 with `reg_rdata` 0x3C → one `reg_rd_en` with addr 0x22, then `tx_data` 0x3C, then `busy` low after `tx_busy` falls.
- Byte 0x41 in IDLE → no register strobes; `frame_err` pulse; `tx_data` 0x15.
- 0x57,0x10, then silence for `TIMEOUT_CYCLES` → `frame_err` pulse, IDLE, no `tx_valid`. A following write frame completes normally.
- Byte arriving during TX_WAIT → `frame_err` pulse; response unaffected; the byte is not decoded as a new frame.
- With `UART_CMD_CHECKSUM_EN`:
  - 0x57,0x10,0xA5,0xE2 → write + ACK.
  - Last byte 0xE3 → NAK, no `reg_wr_en`.

Source files
------------

// File: rtl/uart_cmd_responder_if.sv
// Bus bundle for uart_cmd_responder: UART byte stream, transmit handshake and register-bus access.
interface uart_cmd_responder_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;

  // Responder side
  modport master (
    input  rx_valid, rx_data, tx_busy, reg_rdata,
    output tx_valid, tx_data, reg_wr_en, reg_rd_en, reg_addr, reg_wdata
  );

  // UART / register-file side
  modport slave (
    output rx_valid, rx_data, tx_busy, reg_rdata,
    input  tx_valid, tx_data, reg_wr_en, reg_rd_en, reg_addr, reg_wdata
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// Decodes host read/write frames from UART bytes, drives the register bus and returns one response byte.
// Optional trailing XOR checksum byte per frame when UART_CMD_CHECKSUM_EN is defined.
module uart_cmd_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_cmd_responder_if.master bus,
  output logic                 busy,
  output logic                 frame_err
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA    = 3'd2,
`ifdef UART_CMD_CHECKSUM_EN
    S_CSUM    = 3'd3,
`endif
    S_ACCESS  = 3'd4,
    S_RDWAIT  = 3'd5,
    S_TX_REQ  = 3'd6,
    S_TX_WAIT = 3'd7
  } state_t;

`ifdef UART_CMD_CHECKSUM_EN
  localparam state_t S_FRAME_END = S_CSUM;
`else
  localparam state_t S_FRAME_END = S_ACCESS;
`endif

  state_t           state_q, state_d;
  logic             is_wr_q, is_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             wr_en_q, wr_en_d;
  logic             rd_en_q, rd_en_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic             ferr_q, ferr_d;
  logic             to_tx;
  logic             waiting;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      is_wr_q    <= 1'b0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      is_wr_q    <= is_wr_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      ferr_q     <= ferr_d;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_valid_d = 1'b0;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    ferr_d     = 1'b0;
    busy_d     = 1'b0;
    to_tx      = 1'b0;
    waiting    = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == OP_WR || bus.rx_data == OP_RD) begin
            is_wr_d = (bus.rx_data == OP_WR);
            cnt_d   = '0;
            state_d = S_ADDR;
`ifdef UART_CMD_CHECKSUM_EN
            csum_d  = bus.rx_data;
`endif
          end else begin
            tx_data_d = RSP_NAK;
            ferr_d    = 1'b1;
            to_tx     = 1'b1;
          end
        end
      end
      S_ADDR: begin
        waiting = 1'b1;
        if (bus.rx_valid) begin
          addr_d  = bus.rx_data;
          cnt_d   = '0;
          state_d = is_wr_q ? S_DATA : S_FRAME_END;
`ifdef UART_CMD_CHECKSUM_EN
          csum_d  = csum_q ^ bus.rx_data;
`endif
        end
      end
      S_DATA: begin
        waiting = 1'b1;
        if (bus.rx_valid) begin
          wdata_d = bus.rx_data;
          cnt_d   = '0;
          state_d = S_FRAME_END;
`ifdef UART_CMD_CHECKSUM_EN
          csum_d  = csum_q ^ bus.rx_data;
`endif
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      S_CSUM: begin
        waiting = 1'b1;
        if (bus.rx_valid) begin
          cnt_d = '0;
          if (bus.rx_data == csum_q) begin
            state_d = S_ACCESS;
          end else begin
            tx_data_d = RSP_NAK;
            ferr_d    = 1'b1;
            to_tx     = 1'b1;
          end
        end
      end
`endif
      S_ACCESS: begin
        if (is_wr_q) begin
          tx_data_d = RSP_ACK;
          to_tx     = 1'b1;
        end else begin
          state_d = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        tx_data_d = bus.reg_rdata;
        to_tx     = 1'b1;
      end
      S_TX_REQ: begin
        if (!bus.tx_busy) begin
          tx_valid_d = 1'b1;
          state_d    = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        // The strobe cycle is skipped: tx_busy only rises on the following cycle
        if (!tx_valid_q && !bus.tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout; an arriving byte always beats expiry
    if (waiting && !bus.rx_valid) begin
      if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
        ferr_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Response ready: strobe next cycle when the transmitter is free, else park in TX_REQ
    if (to_tx) begin
      if (!bus.tx_busy) begin
        tx_valid_d = 1'b1;
        state_d    = S_TX_WAIT;
      end else begin
        state_d = S_TX_REQ;
      end
    end

    if (bus.rx_valid && (state_q inside {S_ACCESS, S_RDWAIT, S_TX_REQ, S_TX_WAIT})) ferr_d = 1'b1;

    wr_en_d = (state_d == S_ACCESS) && is_wr_q;
    rd_en_d = (state_d == S_ACCESS) && !is_wr_q;
    busy_d  = (state_d != S_IDLE);
  end

  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.reg_wr_en = wr_en_q;
  assign bus.reg_rd_en = rd_en_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign busy          = busy_q;
  assign frame_err     = ferr_q;
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: directed protocol cases plus randomized frames vs a frame-level model.
module tb_uart_cmd_responder;
  localparam int unsigned TO = 20;
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic frame_err;

  uart_cmd_responder_if bus();

  uart_cmd_responder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  exp_tx[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  int          exp_ferr = 0;
  logic [7:0]  frm[$];
  logic [7:0]  regs[256];
  logic [7:0]  model_mem[256];
  int cyc = 0;
  int hold_until = 0;
  int tx_cnt = 0;

  function automatic logic [7:0] init_val(input int i);
    return (i == 'h22) ? 8'h3C : 8'(i * 37 + 11);
  endfunction

  function automatic logic [7:0] frm_xor(input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++) x ^= frm[i];
    return x;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register file and transmitter models
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i < 256; i++) regs[i] <= init_val(i);
      bus.reg_rdata <= 8'h00;
      bus.tx_busy   <= 1'b0;
      tx_cnt        <= 0;
    end else begin
      if (bus.reg_wr_en) regs[bus.reg_addr] <= bus.reg_wdata;
      if (bus.reg_rd_en) bus.reg_rdata <= regs[bus.reg_addr];
      if (bus.tx_valid) tx_cnt <= int'($urandom_range(3, 12));
      else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
      bus.tx_busy <= bus.tx_valid || (tx_cnt > 1) || (cyc < hold_until);
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output event
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_valid) begin
        check("tx_valid while tx_busy", 16'(bus.tx_busy), 16'd0);
        check("tx response pending", 16'(exp_tx.size() != 0), 16'd1);
        if (exp_tx.size() != 0) check("tx_data", 16'(bus.tx_data), 16'(exp_tx.pop_front()));
      end
      if (bus.reg_wr_en) begin
        check("write pending", 16'(exp_wr.size() != 0), 16'd1);
        if (exp_wr.size() != 0) check("reg write addr/data", {bus.reg_addr, bus.reg_wdata}, exp_wr.pop_front());
      end
      if (bus.reg_rd_en) begin
        check("read pending", 16'(exp_rd.size() != 0), 16'd1);
        if (exp_rd.size() != 0) check("reg read addr", 16'(bus.reg_addr), 16'(exp_rd.pop_front()));
      end
      if (frame_err) begin
        check("frame_err pending", 16'(exp_ferr > 0), 16'd1);
        if (exp_ferr > 0) exp_ferr--;
      end
    end
  end

  // Frame-level reference: what the host should observe for the bytes in frm
  task automatic model_frame();
    int need;
    if (frm[0] != OP_W && frm[0] != OP_R) begin
      exp_tx.push_back(NAK);
      exp_ferr++;
      return;
    end
    need = (frm[0] == OP_W) ? 3 : 2;
`ifdef UART_CMD_CHECKSUM_EN
    need++;
`endif
    if (frm.size() < need) begin
      exp_ferr++;
      return;
    end
`ifdef UART_CMD_CHECKSUM_EN
    if (frm_xor(need - 1) != frm[need-1]) begin
      exp_tx.push_back(NAK);
      exp_ferr++;
      return;
    end
`endif
    if (frm[0] == OP_W) begin
      exp_wr.push_back({frm[1], frm[2]});
      model_mem[frm[1]] = frm[2];
      exp_tx.push_back(ACK);
    end else begin
      exp_rd.push_back(frm[1]);
      exp_tx.push_back(model_mem[frm[1]]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap);
    foreach (frm[i]) begin
      send_byte(frm[i]);
      if (i != frm.size() - 1)
        repeat ((gap < 0) ? int'($urandom_range(0, 4)) : gap) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy || bus.tx_busy) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(name, 16'(busy), 16'd0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    bit hold;
    int k;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
    repeat (3) @(negedge clk);

    check("reset busy",      16'(busy), 16'd0);
    check("reset frame_err", 16'(frame_err), 16'd0);
    check("reset tx_valid",  16'(bus.tx_valid), 16'd0);
    check("reset wr_en",     16'(bus.reg_wr_en), 16'd0);
    check("reset rd_en",     16'(bus.reg_rd_en), 16'd0);
    check("reset tx_data",   16'(bus.tx_data), 16'd0);
    check("reset reg_addr",  16'(bus.reg_addr), 16'd0);
    check("reset reg_wdata", 16'(bus.reg_wdata), 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write frame with latency checks
    frm = '{OP_W, 8'h10, 8'hA5};
`ifdef UART_CMD_CHECKSUM_EN
    frm.push_back(frm_xor(3));
`endif
    model_frame();
    send_frame(0);
    check("write latency wr_en", 16'(bus.reg_wr_en), 16'd1);
    @(negedge clk);
    check("write latency tx_valid", 16'(bus.tx_valid), 16'd1);
    wait_idle("idle after write");

    // Read frame with latency checks
    frm = '{OP_R, 8'h22};
`ifdef UART_CMD_CHECKSUM_EN
    frm.push_back(frm_xor(2));
`endif
    model_frame();
    send_frame(0);
    check("read latency rd_en", 16'(bus.reg_rd_en), 16'd1);
    repeat (2) @(negedge clk);
    check("read latency tx_valid", 16'(bus.tx_valid), 16'd1);
    wait_idle("idle after read");

    // Unknown opcode
    frm = '{8'h41};
    model_frame();
    send_frame(0);
    wait_idle("idle after NAK");

    // Byte arriving exactly when the timeout would fire wins
    frm = '{OP_W, 8'h31, 8'h7E};
`ifdef UART_CMD_CHECKSUM_EN
    frm.push_back(frm_xor(3));
`endif
    model_frame();
    send_frame(TO - 1);
    wait_idle("idle after late-byte write");

    // One cycle later the frame is aborted and the byte starts a new (bad) frame
    frm = '{OP_W};
    model_frame();
    send_frame(0);
    repeat (TO) @(negedge clk);
    frm = '{8'h10};
    model_frame();
    send_frame(0);
    wait_idle("idle after abort+NAK");

    // Silence after address
    frm = '{OP_W, 8'h10};
    model_frame();
    send_frame(0);
    repeat (TO + 4) @(negedge clk);
    check("busy after timeout", 16'(busy), 16'd0);
    wait_idle("idle after timeout");

    // Overrun during TX_WAIT
    frm = '{OP_W, 8'h12, 8'h34};
`ifdef UART_CMD_CHECKSUM_EN
    frm.push_back(frm_xor(3));
`endif
    model_frame();
    send_frame(0);
    k = 0;
    while (!bus.tx_busy && k < 60) begin @(negedge clk); k++; end
    check("tx_busy seen before overrun", 16'(bus.tx_busy), 16'd1);
    exp_ferr++;
    send_byte(OP_R);
    wait_idle("idle after overrun");

`ifdef UART_CMD_CHECKSUM_EN
    frm = '{OP_W, 8'h10, 8'hA5, 8'hE2};
    model_frame();
    send_frame(0);
    wait_idle("idle after good csum");
    frm = '{OP_W, 8'h10, 8'hA5, 8'hE3};
    model_frame();
    send_frame(0);
    wait_idle("idle after bad csum");
`endif

    // Reset mid-frame drops the partial frame
    send_byte(OP_W);
    send_byte(8'h33);
    rst = 1'b1;
    @(negedge clk);
    check("busy after mid-frame reset", 16'(busy), 16'd0);
    check("tx_valid in reset", 16'(bus.tx_valid), 16'd0);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
    @(negedge clk);

    // Randomized frames
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 9));
      hold = ($urandom_range(0, 3) == 0);
      if (kind <= 3)      frm = '{OP_W, 8'($urandom_range(0, 15)), 8'($urandom)};
      else if (kind <= 7) frm = '{OP_R, 8'($urandom_range(0, 15))};
      else if (kind == 8) begin
        frm = '{8'($urandom)};
        while (frm[0] == OP_W || frm[0] == OP_R) frm[0] = 8'($urandom);
      end else begin
        frm = '{OP_W, 8'($urandom_range(0, 15))};
      end
`ifdef UART_CMD_CHECKSUM_EN
      if (kind <= 7) frm.push_back(frm_xor(frm.size()) ^ (($urandom_range(0, 4) == 0) ? 8'h01 << $urandom_range(0, 7) : 8'h00));
`endif
      if (hold) begin
        hold_until = cyc + int'($urandom_range(2, 15));
        @(negedge clk);
      end
      model_frame();
      send_frame(-1);
      if (kind == 9) repeat (TO + 2) @(negedge clk);
      if (!hold && kind != 9 && $urandom_range(0, 4) == 0) begin
        k = 0;
        while (!bus.tx_busy && k < 60) begin @(negedge clk); k++; end
        check("tx_busy seen before random overrun", 16'(bus.tx_busy), 16'd1);
        exp_ferr++;
        send_byte(8'($urandom));
      end
      wait_idle("idle after random frame");
    end

    repeat (5) @(negedge clk);
    check("leftover tx expectations", 16'(exp_tx.size()), 16'd0);
    check("leftover write expectations", 16'(exp_wr.size()), 16'd0);
    check("leftover read expectations", 16'(exp_rd.size()), 16'd0);
    check("leftover frame_err expectations", 16'(exp_ferr), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
